// File: rtl/btn_pkg.sv
// Shared constants and types for the button debounce scheduler.
package btn_pkg;

    localparam logic [1:0] DIR_NORTH = 2'd0;
    localparam logic [1:0] DIR_EAST  = 2'd1;
    localparam logic [1:0] DIR_SOUTH = 2'd2;
    localparam logic [1:0] DIR_WEST  = 2'd3;

    // 10 ms at 50 MHz
    localparam int STL_DEFAULT = 500000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2
    } state_t;

    // Round-robin successor of a button index (wraps 3 -> 0).
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/btn_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin pick: first set request at or after ptr,
// wrapping past index 3 back to 0.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_idx,
    output logic       gnt_any
);

    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;

    // Rotate requests so ptr lands on bit 0, then find the lowest set bit.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[3:0];
        off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot[i]) off = 2'(i);
        end
        gnt_idx = ptr + off;
        gnt_any = |req;
    end

endmodule

// File: rtl/btn_scheduler.sv
// Debounce scheduler: one shared settle counter time-multiplexed across the
// four game buttons, emitting one press/release event per confirmed change.
module btn_scheduler
    import btn_pkg::*;
#(
    parameter int STL_CYCLES = STL_DEFAULT,
    parameter int CNT_W      = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_north,
    input  logic       btn_east,
    input  logic       btn_south,
    input  logic       btn_west,
    output logic [3:0] btn_state,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_dir,
    output logic       evt_press,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0] raw;
    logic [3:0] sync1, sync2;
    logic [3:0] pending;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       rr_ptr, rr_nx;
    logic [1:0]       grant, grant_nx;
    logic             target, target_nx;
    logic [3:0]       btn_state_nx;
    logic             evt_valid_nx;
    logic [1:0]       evt_dir_nx;
    logic             evt_press_nx;
    logic             busy_nx;

    logic [1:0]       arb_idx;
    logic             arb_any;

    assign raw     = {btn_west, btn_south, btn_east, btn_north};
    assign pending = sync2 ^ btn_state;

    // Two-flop synchronizer for the asynchronous button pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    rr_arbiter4 u_arb (
        .req     (pending),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // Next-state and output logic; every register holds unless changed here.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        rr_nx        = rr_ptr;
        grant_nx     = grant;
        target_nx    = target;
        btn_state_nx = btn_state;
        evt_valid_nx = evt_valid;
        evt_dir_nx   = evt_dir;
        evt_press_nx = evt_press;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    grant_nx  = arb_idx;
                    target_nx = sync2[arb_idx];
                    cnt_nx    = '0;
                    state_nx  = SETTLE;
                end
            end
            SETTLE: begin
                if (sync2[grant] != target) begin
                    // Bounce: give the counter to the next button in turn.
                    cnt_nx   = '0;
                    rr_nx    = next_idx(grant);
                    state_nx = IDLE;
                end else if (cnt < CNT_MAX) begin
                    cnt_nx = cnt + CNT_ONE;
                end else begin
                    btn_state_nx[grant] = target;
                    evt_dir_nx          = grant;
                    evt_press_nx        = target;
                    evt_valid_nx        = 1'b1;
                    state_nx            = EMIT;
                end
            end
            EMIT: begin
                // Scheduler stalls here until the consumer takes the event.
                if (evt_valid && evt_ready) begin
                    evt_valid_nx = 1'b0;
                    rr_nx        = next_idx(grant);
                    cnt_nx       = '0;
                    state_nx     = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        busy_nx = (state_nx == SETTLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= 2'd0;
            grant     <= 2'd0;
            target    <= 1'b0;
            btn_state <= 4'b0000;
            evt_valid <= 1'b0;
            evt_dir   <= 2'd0;
            evt_press <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rr_ptr    <= rr_nx;
            grant     <= grant_nx;
            target    <= target_nx;
            btn_state <= btn_state_nx;
            evt_valid <= evt_valid_nx;
            evt_dir   <= evt_dir_nx;
            evt_press <= evt_press_nx;
            busy      <= busy_nx;
        end
    end

endmodule

// File: tb/tb_btn_scheduler.sv
// Directed bench for btn_scheduler: one instance with an 8-cycle settle time
// for the main scenarios, one with a 2-cycle settle time for glitch boundaries.
module tb_btn_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       bn, be, bs, bw;
    logic [3:0] btn_state;
    logic       evt_valid, evt_ready, evt_press, busy;
    logic [1:0] evt_dir;

    logic       w2;
    logic       zero2 = 1'b0;
    logic       rdy2  = 1'b1;
    logic [3:0] st2;
    logic       v2, p2, busy2;
    logic [1:0] d2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    btn_scheduler #(.STL_CYCLES(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_north (bn),
        .btn_east  (be),
        .btn_south (bs),
        .btn_west  (bw),
        .btn_state (btn_state),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_dir   (evt_dir),
        .evt_press (evt_press),
        .busy      (busy)
    );

    btn_scheduler #(.STL_CYCLES(2), .CNT_W(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .btn_north (zero2),
        .btn_east  (zero2),
        .btn_south (zero2),
        .btn_west  (w2),
        .btn_state (st2),
        .evt_valid (v2),
        .evt_ready (rdy2),
        .evt_dir   (d2),
        .evt_press (p2),
        .busy      (busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Tick until evt_valid is seen (bounded); n = edges taken.
    task automatic wait_evt(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!evt_valid && n < max);
    endtask

    int n;
    int cnt_v;
    logic [1:0] ev_press;
    logic [1:0] ev_dir0;

    initial begin
        rst = 1'b1; bn = 0; be = 0; bs = 0; bw = 0; w2 = 0; evt_ready = 1'b1;
        #3;
        chk("rst_state", btn_state, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_busy",  busy, 0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick();

        // Clean press / release on north
        bn = 1;
        wait_evt(40, n);
        chk("press_lat", n, 11);
        chk("press_dir", evt_dir, 0);
        chk("press_bit", evt_press, 1);
        chk("press_state", btn_state, 4'b0001);
        tick();
        chk("press_pulse", evt_valid, 0);
        tick();
        bn = 0;
        wait_evt(40, n);
        chk("rel_lat", n, 11);
        chk("rel_dir", evt_dir, 0);
        chk("rel_bit", evt_press, 0);
        chk("rel_state", btn_state, 4'b0000);
        tick(); tick();

        // Bounce on east
        be = 1;
        tick(); tick(); tick();
        chk("bnc_busy_on", busy, 1);
        be = 0;
        tick(); tick();
        chk("bnc_busy_hold", busy, 1);
        tick();
        chk("bnc_busy_abort", busy, 0);
        chk("bnc_no_evt", evt_valid, 0);
        be = 1;
        wait_evt(40, n);
        chk("bnc_lat", n, 11);
        chk("bnc_dir", evt_dir, 1);
        chk("bnc_press", evt_press, 1);
        chk("bnc_state", btn_state, 4'b0010);
        tick();
        be = 0;
        wait_evt(40, n);
        chk("bnc_rel", evt_press, 0);
        tick(); tick();

        // Simultaneous presses from rr_ptr = 0
        rst = 1'b1; tick(); rst = 1'b0; tick(); tick();
        {bw, bs, be, bn} = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_evt(40, n);
            chk("sim1_valid", evt_valid, 1);
            chk("sim1_dir", evt_dir, i);
        end
        chk("sim1_state", btn_state, 4'b1111);
        tick();
        {bw, bs, be, bn} = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            wait_evt(40, n);
            chk("rel_all_dir", evt_dir, i);
        end
        tick();
        bn = 1; wait_evt(40, n); tick();
        bn = 0; wait_evt(40, n); tick();
        // rr_ptr is now 1
        {bw, bs, be, bn} = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_evt(40, n);
            chk("sim2_valid", evt_valid, 1);
            chk("sim2_dir", evt_dir, (i + 1) % 4);
        end
        tick();
        {bw, bs, be, bn} = 4'b0000;
        rst = 1'b1; tick(); rst = 1'b0; tick(); tick(); tick();

        // Backpressure: north and south pending, consumer stalls
        evt_ready = 1'b0;
        bn = 1; bs = 1;
        wait_evt(40, n);
        chk("bp_first_dir", evt_dir, 0);
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("bp_valid_hold", evt_valid, 1);
            chk("bp_dir_hold", evt_dir, 0);
            chk("bp_press_hold", evt_press, 1);
            chk("bp_busy", busy, 0);
        end
        evt_ready = 1'b1;
        tick();
        chk("bp_accept", evt_valid, 0);
        wait_evt(40, n);
        chk("bp_second_lat", n, 9);
        chk("bp_second_dir", evt_dir, 2);
        chk("bp_state", btn_state, 4'b0101);
        tick(); tick();

        // Reset during SETTLE
        be = 1;
        tick(); tick(); tick(); tick(); tick();
        chk("rs_busy_pre", busy, 1);
        rst = 1'b1;
        #2;
        chk("rs_settle_state", btn_state, 0);
        chk("rs_settle_busy", busy, 0);
        chk("rs_settle_valid", evt_valid, 0);
        tick();
        rst = 1'b0;
        evt_ready = 1'b0;
        wait_evt(40, n);
        chk("rs_relearn_lat", n, 11);
        chk("rs_relearn_dir", evt_dir, 0);
        tick(); tick(); tick();
        // Reset during EMIT
        rst = 1'b1;
        #2;
        chk("rs_emit_valid", evt_valid, 0);
        chk("rs_emit_press", evt_press, 0);
        chk("rs_emit_dir", evt_dir, 0);
        chk("rs_emit_state", btn_state, 0);
        {bw, bs, be, bn} = 4'b0000;
        evt_ready = 1'b1;
        tick();
        rst = 1'b0;
        cnt_v = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (evt_valid) cnt_v++;
        end
        chk("rs_no_evt", cnt_v, 0);
        chk("rs_quiet_state", btn_state, 0);

        // Boundary, 2-cycle settle: 1-cycle glitch on west
        w2 = 1; tick(); w2 = 0;
        cnt_v = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (v2) cnt_v++;
        end
        chk("glitch_no_evt", cnt_v, 0);
        chk("glitch_state", st2, 0);
        // 3-cycle pulse: press then release
        w2 = 1; tick(); tick(); tick(); w2 = 0;
        cnt_v = 0; ev_press = 2'b11; ev_dir0 = 2'd0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (v2) begin
                if (cnt_v < 2) ev_press[cnt_v] = p2;
                if (cnt_v == 0) ev_dir0 = d2;
                cnt_v++;
            end
        end
        chk("pulse_evt_cnt", cnt_v, 2);
        chk("pulse_first_press", ev_press[0], 1);
        chk("pulse_second_press", ev_press[1], 0);
        chk("pulse_dir", ev_dir0, 3);
        chk("pulse_end_state", st2, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
